serial_deser: RTL and testbench
===============================

Name: serial_deser

Overview:
Serial-to-parallel receiver, the far end of the 8-bit shift register's serial_out.
- Collects WIDTH serial bits, qualified by a bit strobe, into a shift register.
- Frames are LSB-first (matches the shift-right sender) or MSB-first (matches the shift-left sender).
- Completed words go to a single-entry output register with a valid/ready handshake and sticky overrun detection.

Parameters:
WIDTH, 8, data word width in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit counter width (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
serial_in  input  1  serial data bit
bit_valid  input  1  serial_in holds a valid bit this cycle
msb_first  input  1  frame order: 0 = LSB first, 1 = MSB first; sampled on first bit of frame
clear  input  1  synchronous abort of partial frame; clears overrun
out  output  WIDTH  assembled parallel word
out_valid  output  1  out holds an unconsumed word
out_ready  input  1  consumer accepts out this cycle
busy  output  1  frame in progress (at least one bit collected)
overrun  output  1  sticky: a completed word was dropped
parity_err  output  1  parity result for word in out (see Optional Feature)

Behaviour:
- Reset (rst=0, async): out=0, out_valid=0, busy=0, overrun=0, parity_err=0. Shift register and bit counter cleared; FSM goes to IDLE. Applies mid-frame too; no partial word survives.
- FSM states:
  - IDLE: bit_valid=1 latches the msb_first value as frame order, stores the first bit, sets count=1 and goes to COLLECT.
  - COLLECT: each bit_valid increments count. When the WIDTH-th bit is sampled, go to IDLE, or to PARITY when the macro is defined.
  - PARITY: exists only when the macro is defined.
- bit_valid=0 cycles: hold all state. No timeout.
- LSB-first: register shifts right, new bit enters MSB; the first received bit ends at out[0].
- MSB-first: register shifts left, new bit enters LSB; the first received bit ends at out[WIDTH-1].
- Completion latency: on the edge that samples the final bit, the word loads into out and out_valid rises. The word is visible the next cycle.
  - Load is allowed if out_valid=0 or out_ready=1 in that cycle.
  - Otherwise the new word is dropped, out is unchanged, and overrun is set.
- Handshake: out_valid && out_ready clears out_valid on that edge, unless a new word loads on the same edge (out_valid then stays 1 with the new data). out is stable while out_valid=1 and out_ready=0.
- busy=1 exactly while the FSM is in COLLECT or PARITY.
- clear=1: FSM to IDLE, count=0, overrun=0. out and out_valid are unaffected.
  - clear wins over a simultaneous bit_valid; that bit is discarded.
  - msb_first changes mid-frame are ignored.
- overrun is cleared only by clear or reset.

Optional Feature:
Macro: SERIAL_DESER_PARITY_CHECK_EN
- Defined:
  - After WIDTH data bits the FSM enters PARITY; the next bit_valid bit is the even-parity bit.
  - The word and parity_err (1 if XOR of data and parity bit is 1) load together on the parity-bit edge, under the same handshake and overrun rules.
  - parity_err is valid while out_valid=1 and is cleared on reset.
- Undefined: no PARITY state, word completes on the WIDTH-th bit, parity_err tied 0.

Decomposition:
- Package serial_pkg holds:
  - FSM state typedef (IDLE, COLLECT, PARITY)
  - default WIDTH constant
  - even-parity function
- Single module; the counter and shift register are too small to warrant a sub-module.

Test Plan:
- LSB-first, WIDTH=8, bits 1,1,0,0,1,0,0,0 on consecutive cycles, out_ready=1 -> out=0x13, out_valid high the cycle after the 8th bit, busy low after.
- MSB-first, bits 0,0,0,1,0,0,1,1 with bit_valid gaps of 0-3 idle cycles -> out=0x13, no state change during gaps.
- out_ready=0: send 0xA5 then 0x3C LSB-first -> out stays 0xA5, overrun=1. Then out_ready=1 for one cycle -> out_valid=0. Then pulse clear -> overrun=0.
- 5 bits of a frame, then clear asserted together with bit_valid, then 8 bits of 0xFF -> out=0xFF, no residue of the aborted bits.
- Async rst low mid-frame (after 3 bits), release, then send 0x5A -> all outputs 0 during reset; out=0x5A afterwards.
- With SERIAL_DESER_PARITY_CHECK_EN: 0x13 LSB-first + parity bit 1 -> parity_err=0. Same data + parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial_deser receiver.
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

    // Returns 1 when data plus its even-parity bit has an odd number of ones.
    function automatic logic parity_error(input logic [MAX_WIDTH-1:0] data, input logic parity_bit);
        return (^data) ^ parity_bit;
    endfunction

endpackage

// File: rtl/serial_deser.sv
// Serial-to-parallel receiver with a single-entry valid/ready output register.
// Define SERIAL_DESER_PARITY_CHECK_EN to expect a trailing even-parity bit per frame.
module serial_deser
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic               order_reg, order_next;
    logic [WIDTH-1:0]   out_reg, out_next;
    logic               out_valid_reg, out_valid_next;
    logic               overrun_reg, overrun_next;

    logic               shift_order;
    logic [WIDTH-1:0]   shifted;
    logic               word_done;
    logic [WIDTH-1:0]   word;
    logic               word_perr;

    // The first bit of a frame uses the live msb_first; later bits use the latched order.
    assign shift_order = (state_reg == IDLE) ? msb_first : order_reg;
    assign shifted     = shift_order ? {shreg_reg[WIDTH-2:0], serial_in}
                                     : {serial_in, shreg_reg[WIDTH-1:1]};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shreg_next = shreg_reg;
        order_next = order_reg;
        word_done  = 1'b0;
        word       = shifted;
        word_perr  = 1'b0;

        if (clear) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (bit_valid) begin
            case (state_reg)
                IDLE: begin
                    order_next = msb_first;
                    shreg_next = shifted;
                    cnt_next   = CNT_W'(1);
                    state_next = COLLECT;
                end
                COLLECT: begin
                    shreg_next = shifted;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_DESER_PARITY_CHECK_EN
                        cnt_next   = CNT_W'(WIDTH);
                        state_next = PARITY;
`else
                        cnt_next   = '0;
                        state_next = IDLE;
                        word_done  = 1'b1;
`endif
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
`ifdef SERIAL_DESER_PARITY_CHECK_EN
                PARITY: begin
                    word       = shreg_reg;
                    word_perr  = parity_error(MAX_WIDTH'(shreg_reg), serial_in);
                    word_done  = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
`endif
                default: begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output register: load when empty or being drained, otherwise flag the drop.
    always_comb begin
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        overrun_next   = clear ? 1'b0 : overrun_reg;
        if (word_done) begin
            if (!out_valid_reg || out_ready) begin
                out_next       = word;
                out_valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            shreg_reg     <= '0;
            order_reg     <= 1'b0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shreg_reg     <= shreg_next;
            order_reg     <= order_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            overrun_reg   <= overrun_next;
        end
    end

`ifdef SERIAL_DESER_PARITY_CHECK_EN
    logic parity_err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_reg <= 1'b0;
        end else if (word_done && (!out_valid_reg || out_ready)) begin
            parity_err_reg <= word_perr;
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != IDLE);
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_serial_deser.sv
// Directed self-checking bench for serial_deser (WIDTH=8).
module tb_serial_deser;

`ifdef SERIAL_DESER_PARITY_CHECK_EN
    localparam int FRAME_N = 9;
`else
    localparam int FRAME_N = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       bit_valid;
    logic       msb_first;
    logic       clear;
    logic [7:0] out;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    serial_deser #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .msb_first  (msb_first),
        .clear      (clear),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Bit sequence in transmission order; index 8 holds the correct even-parity bit.
    function automatic logic [15:0] frame_seq(input logic [7:0] d, input logic msb);
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[i] = msb ? d[7-i] : d[i];
        s[8] = ^d;
        return s;
    endfunction

    task automatic send_bits(input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            serial_in = seq[i];
            bit_valid = 1'b1;
        end
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic msb);
        msb_first = msb;
        send_bits(frame_seq(d, msb), FRAME_N);
    endtask

    task automatic test_reset;
        rst = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; msb_first = 1'b0;
        clear = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        rst = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_lsb_first;
        out_ready = 1'b1;
        send_frame(8'h13, 1'b0);
        checks++; if (out !== 8'h13) begin errors++; $display("FAIL lsb_out: got %h expected 13", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lsb_out_valid: got %b expected 1", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lsb_busy: got %b expected 0", busy); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL lsb_parity_err: got %b expected 0", parity_err); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lsb_consumed: got %b expected 0", out_valid); end
        $display("lsb_first: out=%h", out);
    endtask

    task automatic test_msb_gaps;
        int          gaps [9] = '{0, 1, 2, 3, 0, 2, 1, 0, 0};
        logic [15:0] seq;
        seq = frame_seq(8'h13, 1'b1);
        out_ready = 1'b1;
        msb_first = 1'b1;
        for (int i = 0; i < FRAME_N; i++) begin
            @(negedge clk);
            serial_in = seq[i];
            bit_valid = 1'b1;
            if (i == 1) msb_first = 1'b0;
            for (int g = 0; g < gaps[i]; g++) begin
                @(negedge clk);
                bit_valid = 1'b0;
                serial_in = ~serial_in;
                if (g > 0) begin
                    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_gap_busy: got %b expected 1", busy); end
                    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL msb_gap_valid: got %b expected 0", out_valid); end
                end
            end
        end
        @(negedge clk);
        bit_valid = 1'b0;
        checks++; if (out !== 8'h13) begin errors++; $display("FAIL msb_out: got %h expected 13", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL msb_out_valid: got %b expected 1", out_valid); end
        msb_first = 1'b0;
        @(negedge clk);
        $display("msb_gaps: out=%h", out);
    endtask

    task automatic test_overrun;
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        checks++; if (out !== 8'hA5) begin errors++; $display("FAIL ovr_first_out: got %h expected a5", out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b expected 0", overrun); end
        send_frame(8'h3C, 1'b0);
        checks++; if (out !== 8'hA5) begin errors++; $display("FAIL ovr_held_out: got %h expected a5", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid: got %b expected 1", out_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %b expected 0", out_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
        checks++; if (out !== 8'hA5) begin errors++; $display("FAIL ovr_clear_out: got %h expected a5", out); end
        $display("overrun: out=%h overrun=%b", out, overrun);
    endtask

    task automatic test_clear_abort;
        out_ready = 1'b1;
        msb_first = 1'b0;
        send_bits(16'b0000_0000_0000_1010, 5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_partial_busy: got %b expected 1", busy); end
        clear = 1'b1; bit_valid = 1'b1; serial_in = 1'b1;
        @(negedge clk);
        clear = 1'b0; bit_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        send_frame(8'hFF, 1'b0);
        checks++; if (out !== 8'hFF) begin errors++; $display("FAIL abort_out: got %h expected ff", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_valid: got %b expected 1", out_valid); end
        @(negedge clk);
        $display("clear_abort: out=%h", out);
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        msb_first = 1'b0;
        send_bits(16'h0007, 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b expected 1", busy); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out !== 8'h00) begin errors++; $display("FAIL areset_out: got %h expected 00", out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b expected 0", out_valid); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send_frame(8'h5A, 1'b0);
        checks++; if (out !== 8'h5A) begin errors++; $display("FAIL areset_after_out: got %h expected 5a", out); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_after_valid: got %b expected 1", out_valid); end
        @(negedge clk);
        $display("async_reset: out=%h", out);
    endtask

`ifdef SERIAL_DESER_PARITY_CHECK_EN
    task automatic test_parity;
        logic [15:0] seq;
        out_ready = 1'b1;
        msb_first = 1'b0;
        seq = frame_seq(8'h13, 1'b0);
        seq[8] = 1'b1;
        send_bits(seq, 9);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", parity_err); end
        @(negedge clk);
        seq[8] = 1'b0;
        send_bits(seq, 9);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", parity_err); end
        checks++; if (out !== 8'h13) begin errors++; $display("FAIL parity_out: got %h expected 13", out); end
        @(negedge clk);
        $display("parity: parity_err=%b", parity_err);
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_gaps();
        test_overrun();
        test_clear_abort();
        test_async_reset();
`ifdef SERIAL_DESER_PARITY_CHECK_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
